// File: rtl/addsub_seq_if.sv
// Operand/result handshake bundle for addsub_seq.
// The master issues operands and accepts results; the slave is the arithmetic unit.
interface addsub_seq_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             sat;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             ovf;
   logic             zero;
   logic             neg;

   modport master (
      output in_valid, a, b, sub, sat, out_ready,
      input  in_ready, out_valid, result, cout, ovf, zero, neg
   );

   modport slave (
      input  in_valid, a, b, sub, sat, out_ready,
      output in_ready, out_valid, result, cout, ovf, zero, neg
   );
endinterface

// File: rtl/addsub_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock, with
// carry/overflow/zero/negative flags and optional signed saturation.
module addsub_seq #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input logic          clk,
   input logic          rst_n,
   addsub_seq_if.slave  bus
);
   localparam int unsigned N     = WIDTH / CHUNK;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned SUM_W = CHUNK + 1;
   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_carry;
   logic               r_sat;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_result;
   logic               r_cout;
   logic               r_ovf;
   logic               r_zero;
   logic               r_neg;

   logic               w_accept;
   logic               w_calc;
   logic               w_last;
   logic [CHUNK-1:0]   w_a_k;
   logic [CHUNK-1:0]   w_b_k;
   logic [SUM_W-1:0]   w_sum;
   logic [WIDTH-1:0]   w_next_acc;
   logic               w_ovf;
   logic [WIDTH-1:0]   w_final;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_calc   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_accept = bus.in_valid;
            if (bus.in_valid) w_next = S_CALC;
         end
         S_CALC: begin
            w_calc = 1'b1;
            if (w_last) w_next = S_DONE;
         end
         S_DONE: if (bus.out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Chunk adder over the currently selected slice
   always_comb begin
      w_a_k      = '0;
      w_b_k      = '0;
      w_next_acc = r_acc;
      w_last     = (r_cnt == CNT_W'(N - 1));
      for (int unsigned k = 0; k < N; k++) begin
         if (r_cnt == CNT_W'(k)) begin
            w_a_k = r_a[k*CHUNK +: CHUNK];
            w_b_k = r_b[k*CHUNK +: CHUNK];
         end
      end
      w_sum = {1'b0, w_a_k} + {1'b0, w_b_k} + SUM_W'(r_carry);
      for (int unsigned k = 0; k < N; k++) begin
         if (r_cnt == CNT_W'(k)) w_next_acc[k*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
      end
      // Same-sign operands with a differing result sign == MSB carry-in xor carry-out
      w_ovf   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_next_acc[WIDTH-1] != r_a[WIDTH-1]);
      w_final = w_next_acc;
      if (r_sat && w_ovf) w_final = r_a[WIDTH-1] ? MIN_NEG : MAX_POS;
   end

   // Operand capture, chunk iteration and result/flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_sat    <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b0;
         r_neg    <= 1'b0;
      end else if (w_accept) begin
         r_a     <= bus.a;
         r_b     <= bus.b ^ {WIDTH{bus.sub}};
         r_sat   <= bus.sat;
         r_carry <= bus.sub;
         r_cnt   <= '0;
      end else if (w_calc) begin
         r_acc   <= w_next_acc;
         r_carry <= w_sum[CHUNK];
         r_cnt   <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_result <= w_final;
            r_cout   <= w_sum[CHUNK];
            r_ovf    <= w_ovf;
            r_zero   <= (w_final == '0);
            r_neg    <= w_final[WIDTH-1];
         end
      end
   end

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.result    = r_result;
   assign bus.cout      = r_cout;
   assign bus.ovf       = r_ovf;
   assign bus.zero      = r_zero;
   assign bus.neg       = r_neg;
endmodule
